// File: rtl/cla64_issue_stage_if.sv
// cla64_issue_stage_if
//
// Groups the op-request and result handshakes of cla64_issue_stage.
//
//   in_valid / in_ready      op request handshake
//   in_op                    00 ADD, 01 SUB, 10 ADC, 11 SBB
//   in_a, in_b               64-bit operands
//   in_tag                   opaque tag carried alongside the op
//   out_valid / out_ready    result handshake
//   out_result               registered sum (or saturated value)
//   out_ovf                  registered signed overflow
//   out_carry                registered carry-out (SUB/SBB: 1 = no borrow)
//   out_tag                  tag of the result
//
// Modports: master = producer/consumer side, slave = the issue stage.

interface cla64_issue_stage_if #(
    parameter int unsigned TAG_W = 4
) ();

    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_op;
    logic [63:0]      in_a;
    logic [63:0]      in_b;
    logic [TAG_W-1:0] in_tag;

    logic             out_valid;
    logic             out_ready;
    logic [63:0]      out_result;
    logic             out_ovf;
    logic             out_carry;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_op, in_a, in_b, in_tag, out_ready,
        input  in_ready, out_valid, out_result, out_ovf, out_carry, out_tag
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, in_tag, out_ready,
        output in_ready, out_valid, out_result, out_ovf, out_carry, out_tag
    );

endinterface

// File: rtl/cla64_issue_stage.sv
// cla64_issue_stage
//
// Two-stage operand-issue / result-capture wrapper around an external 64-bit CLA adder.
// S1 registers the accepted op and drives the adder combinationally; S2 captures the
// adder's sum, signed overflow and a reconstructed carry-out. A carry flag, updated as
// each op leaves S1, feeds ADC/SBB so long chains build multi-precision arithmetic.
//
// Ports:
//   clk, rst_n     clock (rising edge), asynchronous active-low reset
//   bus            cla64_issue_stage_if.slave: request and result handshakes
//   carry_clr      one-cycle pulse clearing the carry flag (wins over an update)
//   add_a, add_b   adder operands (add_b is ~B for SUB/SBB)
//   add_cin        adder carry-in
//   add_s, add_ovf adder sum and signed overflow, combinational return
//
// Parameters:
//   TAG_W          tag width (must match the interface instance)
//   CARRY_RST      reset value of the carry flag
//
// Configuration macro: CLA64_ISSUE_SAT_EN
//   defined   -> on signed overflow S2 captures the signed saturation value
//   undefined -> S2 always captures the wrapped adder sum

module cla64_issue_stage #(
    parameter int unsigned TAG_W     = 4,
    parameter bit          CARRY_RST = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    cla64_issue_stage_if.slave       bus,
    input  logic                     carry_clr,
    output logic [63:0]              add_a,
    output logic [63:0]              add_b,
    output logic                     add_cin,
    input  logic [63:0]              add_s,
    input  logic                     add_ovf
);

    typedef enum logic [1:0] {
        OpAdd = 2'b00,
        OpSub = 2'b01,
        OpAdc = 2'b10,
        OpSbb = 2'b11
    } op_e;

    // S1: registered operand stage
    logic             s1_valid_q, s1_valid_d;
    op_e              s1_op_q, s1_op_d;
    logic [63:0]      s1_a_q, s1_a_d;
    logic [63:0]      s1_b_q, s1_b_d;
    logic [TAG_W-1:0] s1_tag_q, s1_tag_d;

    // S2: registered result stage
    logic             out_valid_q, out_valid_d;
    logic [63:0]      out_result_q, out_result_d;
    logic             out_ovf_q, out_ovf_d;
    logic             out_carry_q, out_carry_d;
    logic [TAG_W-1:0] out_tag_q, out_tag_d;

    // Multi-precision carry flag
    logic             carry_q, carry_d;

    logic s2_free;
    logic s1_adv;
    logic in_ready;
    logic accept;
    logic c63;
    logic cout;
    logic [63:0] result_sel;

    // Handshake. in_ready depends only on state and out_ready, never on in_valid.
    assign s2_free  = ~out_valid_q | bus.out_ready;
    assign s1_adv   = s1_valid_q & s2_free;
    assign in_ready = ~s1_valid_q | s2_free;
    assign accept   = bus.in_valid & in_ready;

    // Adder drive from S1
    always_comb begin
        add_a   = s1_a_q;
        add_b   = s1_b_q;
        add_cin = 1'b0;
        unique case (s1_op_q)
            OpAdd: begin
                add_cin = 1'b0;
            end
            OpSub: begin
                add_b   = ~s1_b_q;
                add_cin = 1'b1;
            end
            OpAdc: begin
                add_cin = carry_q;
            end
            OpSbb: begin
                add_b   = ~s1_b_q;
                add_cin = carry_q;
            end
        endcase
    end

    // The adder exports only the sum; recover the carry into bit 63 from the sum bit
    // and then form the carry out of the MSB.
    assign c63  = add_s[63] ^ add_a[63] ^ add_b[63];
    assign cout = (add_a[63] & add_b[63]) | ((add_a[63] ^ add_b[63]) & c63);

`ifdef CLA64_ISSUE_SAT_EN
    // Signed saturation: overflow direction follows the sign of operand A.
    always_comb begin
        result_sel = add_s;
        if (add_ovf) begin
            result_sel = add_a[63] ? 64'h8000_0000_0000_0000 : 64'h7FFF_FFFF_FFFF_FFFF;
        end
    end
`else
    assign result_sel = add_s;
`endif

    // S1 next state
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_op_d    = s1_op_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_tag_d   = s1_tag_q;
        if (accept) begin
            s1_valid_d = 1'b1;
            s1_op_d    = op_e'(bus.in_op);
            s1_a_d     = bus.in_a;
            s1_b_d     = bus.in_b;
            s1_tag_d   = bus.in_tag;
        end else if (s1_adv) begin
            s1_valid_d = 1'b0;
        end
    end

    // S2 next state
    always_comb begin
        out_valid_d  = out_valid_q;
        out_result_d = out_result_q;
        out_ovf_d    = out_ovf_q;
        out_carry_d  = out_carry_q;
        out_tag_d    = out_tag_q;
        if (s1_adv) begin
            out_valid_d  = 1'b1;
            out_result_d = result_sel;
            out_ovf_d    = add_ovf;
            out_carry_d  = cout;
            out_tag_d    = s1_tag_q;
        end else if (bus.out_ready) begin
            out_valid_d  = 1'b0;
        end
    end

    // Carry flag: the op entering S1 on the same edge sees the new value next cycle,
    // so back-to-back ADC/SBB chains need no stall.
    always_comb begin
        carry_d = carry_q;
        if (carry_clr) begin
            carry_d = 1'b0;
        end else if (s1_adv) begin
            carry_d = cout;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_op_q    <= OpAdd;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_tag_q   <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_op_q    <= s1_op_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s1_tag_q   <= s1_tag_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_ovf_q    <= 1'b0;
            out_carry_q  <= 1'b0;
            out_tag_q    <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_ovf_q    <= out_ovf_d;
            out_carry_q  <= out_carry_d;
            out_tag_q    <= out_tag_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry_q <= CARRY_RST;
        end else begin
            carry_q <= carry_d;
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_result = out_result_q;
    assign bus.out_ovf    = out_ovf_q;
    assign bus.out_carry  = out_carry_q;
    assign bus.out_tag    = out_tag_q;

endmodule

// File: doc/cla64_issue_stage.md
Name: cla64_issue_stage

Overview:
- Pipelined operand-issue and result-capture stage wrapped around the 64-bit CLA adder.
- Accepts add/subtract ops on a valid/ready interface and drives the adder's operand and carry-in ports from a registered operand stage (S1).
- Captures sum, overflow and derived carry-out into a registered result stage (S2).
- Holds a carry flag so ADC/SBB chains build multi-precision (128-bit and wider) arithmetic.

Parameters:
- TAG_W, 4: width of the opaque tag passed from input to output alongside each op.
- CARRY_RST, 0: reset value of the carry flag.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  op request valid.
- in_ready  out  1  stage can accept an op this cycle.
- in_op  in  2  opcode: 00 ADD, 01 SUB, 10 ADC, 11 SBB.
- in_a  in  64  operand A.
- in_b  in  64  operand B.
- in_tag  in  TAG_W  op tag.
- carry_clr  in  1  single-cycle pulse that clears the carry flag.
- add_a  out  64  adder operand A; equals S1 A.
- add_b  out  64  adder operand B; equals S1 B, or ~B for SUB/SBB.
- add_cin  out  1  adder carry-in.
- add_s  in  64  adder sum; combinational return.
- add_ovf  in  1  adder signed overflow; combinational return.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_result  out  64  registered sum.
- out_ovf  out  1  registered signed overflow.
- out_carry  out  1  registered carry-out; for SUB/SBB, 1 = no borrow.
- out_tag  out  TAG_W  tag of the result.

Behaviour:
- Reset asserted: s1_valid=0, out_valid=0, out_result=0, out_ovf=0, out_carry=0, out_tag=0, carry flag=CARRY_RST, S1 data=0. Hence add_a=0, add_b=0, add_cin=CARRY_RST-independent 0 (S1 op resets to ADD). Reset may assert mid-operation; in-flight ops are discarded with no partial output.
- Handshake:
  - s2_free = ~out_valid | out_ready.
  - s1_adv = s1_valid & s2_free.
  - in_ready = ~s1_valid | s2_free. It depends only on registered state and out_ready, never on in_valid.
  - Input accepted on in_valid & in_ready; loads S1 (op, a, b, tag).
  - S1 is cleared (s1_valid=0) when s1_adv fires with no new accept.
- Adder drive, combinational from S1:
  - ADD: b, cin=0.
  - SUB: ~b, cin=1.
  - ADC: b, cin=C.
  - SBB: ~b, cin=C.
  - C is the carry flag register.
- Carry-out:
  - c63 = add_s[63] ^ add_a[63] ^ add_b[63].
  - cout = (add_a[63]&add_b[63]) | ((add_a[63]^add_b[63])&c63).
- On s1_adv, S2 loads add_s, add_ovf, cout and tag, and sets out_valid. In the same edge the carry flag loads cout.
- The next op enters S1 on that same edge, so it sees the updated flag in the following cycle. There is no chaining hazard and no stall.
- out_valid holds, with all result fields stable, until out_ready is high. out_valid is cleared on out_ready & ~s1_adv.
- Latency: op accepted at edge N gives out_valid high after edge N+1. Throughput is 1 op/cycle while out_ready=1.
- Full condition (S1 and S2 valid, out_ready=0): in_ready=0. No op is lost, dropped or reordered.
- carry_clr: flag becomes 0 at the next edge. carry_clr has priority over a simultaneous s1_adv flag update; the S2 out_carry still records the true cout.
- Values are modulo 2^64; signed overflow comes solely from add_ovf.

Optional Feature:
- Macro: CLA64_ISSUE_SAT_EN.
- Defined: when add_ovf=1, S2 captures signed saturation instead of add_s: 0x7FFF_FFFF_FFFF_FFFF if add_a[63]=0, else 0x8000_0000_0000_0000. out_ovf and out_carry are unchanged; the carry flag still takes the raw cout.
- Undefined: out_result is always the wrapped add_s. No saturation logic is present.

Test Plan:
- ADD a=1, b=1, out_ready=1 -> out_valid 2 cycles after accept, result=2, ovf=0, carry=0.
- ADD a=0x7FFF_FFFF_FFFF_FFFF, b=1 -> result=0x8000_0000_0000_0000, ovf=1, carry=0. With CLA64_ISSUE_SAT_EN defined -> result=0x7FFF_FFFF_FFFF_FFFF.
- Back-to-back ADD a=0xFFFF_FFFF_FFFF_FFFF, b=1 then ADC a=0, b=0 -> results 0 (carry=1) then 1 (carry=0). This is 128-bit 2^64 with no bubble.
- SUB a=5, b=7 -> result=0xFFFF_FFFF_FFFF_FFFE, carry=0. Then SBB a=0, b=0 -> result=0xFFFF_FFFF_FFFF_FFFF.
- out_ready=0 while issuing 3 ops -> in_ready drops after 2 accepts. Release out_ready -> all 3 results in order, tags match, no duplicates.
- Assert rst_n low with S1 and S2 full -> out_valid=0 immediately (asynchronous). Carry flag=CARRY_RST. The first op after release completes normally.
